timer_reg_arb: RTL

- Two-requester register-port arbiter and sequencer in front of the d_ip_timer register interface (addr/wr_en/mod_en/wdata/rdata).
- Lets two masters share the single timer register port, e.g. a CPU bus bridge and an autonomous reconfiguration engine.
- Serialises their accesses with round-robin arbitration.
- Drives a one-cycle access strobe and returns read data with a valid pulse.

---
 rtl/timer_reg_arb_if.sv | 38 +++
 rtl/timer_reg_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/timer_reg_arb_if.sv
// Register-port bundle between two requesters, the arbiter and the d_ip_timer register interface.
// The slave modport is the arbiter's view; master is the requester/timer side.
interface timer_reg_arb_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              lock0;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] t_addr;
    logic              t_wr_en;
    logic              t_mod_en;
    logic [DATA_W-1:0] t_wdata;
    logic [DATA_W-1:0] t_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, t_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, t_addr, t_wr_en, t_mod_en, t_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, t_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, t_addr, t_wr_en, t_mod_en, t_wdata
    );
endinterface

// File: rtl/timer_reg_arb.sv
// Round-robin arbiter/sequencer sharing one d_ip_timer register port between two requesters.
// Defining TIMER_REG_ARB_LOCK_EN enables lock-hold arbitration via lock0/lock1.
module timer_reg_arb #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_b,
    timer_reg_arb_if.slave bus,
    output logic           busy
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] CNT_INIT   = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
        $fatal(1, "timer_reg_arb: RD_LAT=%0d outside 0..3", RD_LAT);
    end

    logic [1:0]        state_r, state_nxt_s;
    logic [1:0]        cnt_r, cnt_nxt_s;
    logic              last_gnt_r, last_gnt_nxt_s;
    logic              sel_r, sel_nxt_s;
    logic [ADDR_W-1:0] t_addr_r, t_addr_nxt_s;
    logic [DATA_W-1:0] t_wdata_r, t_wdata_nxt_s;
    logic              t_wr_en_r, t_wr_en_nxt_s;
    logic              t_mod_en_r, t_mod_en_nxt_s;
    logic              gnt0_r, gnt0_nxt_s;
    logic              gnt1_r, gnt1_nxt_s;
    logic              rvalid0_r, rvalid0_nxt_s;
    logic              rvalid1_r, rvalid1_nxt_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_nxt_s;
    logic [DATA_W-1:0] rdata1_r, rdata1_nxt_s;
    logic              busy_r;
    logic              capture_s;
    logic              cand0_s, cand1_s, pick_s, start_s;

`ifdef TIMER_REG_ARB_LOCK_EN
    logic lock_act_r;
    logic lock_id_r;

    // Lock owner and hold flag are captured together with every issued request.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_act_r <= 1'b0;
            lock_id_r  <= 1'b0;
        end else if (start_s) begin
            lock_act_r <= pick_s ? bus.lock1 : bus.lock0;
            lock_id_r  <= pick_s;
        end else begin
            lock_act_r <= lock_act_r;
            lock_id_r  <= lock_id_r;
        end
    end

    assign cand0_s = bus.req0 && !(lock_act_r && lock_id_r);
    assign cand1_s = bus.req1 && !(lock_act_r && !lock_id_r);
`else
    logic unused_lock_s;
    assign unused_lock_s = bus.lock0 ^ bus.lock1;
    assign cand0_s       = bus.req0;
    assign cand1_s       = bus.req1;
`endif

    // On a tie the requester that did not win last time is chosen.
    assign pick_s  = (cand0_s && cand1_s) ? ~last_gnt_r : cand1_s;
    assign start_s = (state_r == ST_IDLE) && (cand0_s || cand1_s);

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        last_gnt_nxt_s = last_gnt_r;
        sel_nxt_s      = sel_r;
        t_addr_nxt_s   = t_addr_r;
        t_wdata_nxt_s  = t_wdata_r;
        t_wr_en_nxt_s  = 1'b0;
        t_mod_en_nxt_s = 1'b0;
        gnt0_nxt_s     = 1'b0;
        gnt1_nxt_s     = 1'b0;
        capture_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s    = ST_ACCESS;
                    sel_nxt_s      = pick_s;
                    last_gnt_nxt_s = pick_s;
                    t_mod_en_nxt_s = 1'b1;
                    t_wr_en_nxt_s  = pick_s ? bus.we1 : bus.we0;
                    t_addr_nxt_s   = pick_s ? bus.addr1 : bus.addr0;
                    t_wdata_nxt_s  = pick_s ? bus.wdata1 : bus.wdata0;
                    gnt0_nxt_s     = ~pick_s;
                    gnt1_nxt_s     = pick_s;
                end else begin
                    t_addr_nxt_s  = {ADDR_W{1'b0}};
                    t_wdata_nxt_s = {DATA_W{1'b0}};
                end
            end
            ST_ACCESS: begin
                // t_wr_en_r still holds the latched direction during ACCESS.
                if (t_wr_en_r || (RD_LAT == 0)) begin
                    capture_s     = ~t_wr_en_r;
                    state_nxt_s   = ST_IDLE;
                    t_addr_nxt_s  = {ADDR_W{1'b0}};
                    t_wdata_nxt_s = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                    cnt_nxt_s   = CNT_INIT;
                end
            end
            ST_WAIT_RD: begin
                if (cnt_r == 2'd0) begin
                    capture_s     = 1'b1;
                    state_nxt_s   = ST_IDLE;
                    t_addr_nxt_s  = {ADDR_W{1'b0}};
                    t_wdata_nxt_s = {DATA_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                t_addr_nxt_s  = {ADDR_W{1'b0}};
                t_wdata_nxt_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Read-data capture steers t_rdata to the requester that owns the access.
    always_comb begin
        rdata0_nxt_s  = rdata0_r;
        rdata1_nxt_s  = rdata1_r;
        rvalid0_nxt_s = 1'b0;
        rvalid1_nxt_s = 1'b0;
        if (capture_s && sel_r) begin
            rdata1_nxt_s  = bus.t_rdata;
            rvalid1_nxt_s = 1'b1;
        end else if (capture_s) begin
            rdata0_nxt_s  = bus.t_rdata;
            rvalid0_nxt_s = 1'b1;
        end else begin
            rdata0_nxt_s = rdata0_r;
        end
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 2'd0;
            last_gnt_r <= 1'b1;
            sel_r      <= 1'b0;
            t_addr_r   <= {ADDR_W{1'b0}};
            t_wdata_r  <= {DATA_W{1'b0}};
            t_wr_en_r  <= 1'b0;
            t_mod_en_r <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            rdata0_r   <= {DATA_W{1'b0}};
            rdata1_r   <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
            sel_r      <= sel_nxt_s;
            t_addr_r   <= t_addr_nxt_s;
            t_wdata_r  <= t_wdata_nxt_s;
            t_wr_en_r  <= t_wr_en_nxt_s;
            t_mod_en_r <= t_mod_en_nxt_s;
            gnt0_r     <= gnt0_nxt_s;
            gnt1_r     <= gnt1_nxt_s;
            rvalid0_r  <= rvalid0_nxt_s;
            rvalid1_r  <= rvalid1_nxt_s;
            rdata0_r   <= rdata0_nxt_s;
            rdata1_r   <= rdata1_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.t_addr   = t_addr_r;
    assign bus.t_wdata  = t_wdata_r;
    assign bus.t_wr_en  = t_wr_en_r;
    assign bus.t_mod_en = t_mod_en_r;
    assign bus.gnt0     = gnt0_r;
    assign bus.gnt1     = gnt1_r;
    assign bus.rvalid0  = rvalid0_r;
    assign bus.rvalid1  = rvalid1_r;
    assign bus.rdata0   = rdata0_r;
    assign bus.rdata1   = rdata1_r;
    assign busy         = busy_r;
endmodule
